// File: rtl/sys_seq_ctrl.sv
// sys_seq_ctrl: systolic-array sequencer (weight load, compute, skew drain, done handshake)
// Ports: clk; rst (asynchronous, active-low); start/len/abort from the layer scheduler;
//   busy/done job status; w_load/w_row weight-load strobe and row index;
//   act_en/act_idx activation feed into row 0; ps_en per-row skewed accumulate enables.
// Option: SYS_SEQ_WEIGHT_REUSE_EN adds input reuse_w, which skips the weight load
//   when the previously loaded weights are still valid.
module sys_seq_ctrl #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int LEN_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic                    abort,
`ifdef SYS_SEQ_WEIGHT_REUSE_EN
  input  logic                    reuse_w,
`endif
  output logic                    busy,
  output logic                    done,
  output logic                    w_load,
  output logic [$clog2(ROWS)-1:0] w_row,
  output logic                    act_en,
  output logic [LEN_W-1:0]        act_idx,
  output logic [ROWS-1:0]         ps_en
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(ROWS + COLS);
  typedef enum logic [2:0] {IDLE, LOAD_W, COMPUTE, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [LEN_W-1:0] len_m1, len_m1_n, act_idx_n;
  logic [RW-1:0] w_row_n;
  logic [ROWS-1:0] ps_en_n;
  logic busy_n, done_n, w_load_n, act_en_n, reuse;
`ifdef SYS_SEQ_WEIGHT_REUSE_EN
  logic w_valid, w_valid_n;
  assign reuse = reuse_w & w_valid;
`else
  assign reuse = 1'b0;
`endif
  // w_row and act_idx double as the LOAD_W and COMPUTE phase counters; cnt times DRAIN.
  always_comb begin
    state_n   = state;
    busy_n    = busy;
    done_n    = 1'b0;
    w_load_n  = w_load;
    w_row_n   = w_row;
    act_en_n  = act_en;
    act_idx_n = act_idx;
    cnt_n     = cnt;
    len_m1_n  = len_m1;
`ifdef SYS_SEQ_WEIGHT_REUSE_EN
    w_valid_n = w_valid;
`endif
    if (abort && state != IDLE) begin
      state_n   = IDLE;
      busy_n    = 1'b0;
      w_load_n  = 1'b0;
      w_row_n   = '0;
      act_en_n  = 1'b0;
      act_idx_n = '0;
      cnt_n     = '0;
`ifdef SYS_SEQ_WEIGHT_REUSE_EN
      w_valid_n = (state == LOAD_W) ? 1'b0 : w_valid;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          busy_n   = 1'b1;
          cnt_n    = '0;
          len_m1_n = len - LEN_W'(1);
          if (len == '0) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else if (reuse) begin
            state_n   = COMPUTE;
            act_en_n  = 1'b1;
            act_idx_n = '0;
          end else begin
            state_n  = LOAD_W;
            w_load_n = 1'b1;
            w_row_n  = '0;
          end
        end
        LOAD_W: if (w_row == RW'(ROWS - 1)) begin
          state_n   = COMPUTE;
          w_load_n  = 1'b0;
          w_row_n   = '0;
          act_en_n  = 1'b1;
          act_idx_n = '0;
`ifdef SYS_SEQ_WEIGHT_REUSE_EN
          w_valid_n = 1'b1;
`endif
        end else w_row_n = w_row + RW'(1);
        COMPUTE: if (act_idx == len_m1) begin
          state_n   = DRAIN;
          act_en_n  = 1'b0;
          act_idx_n = '0;
          cnt_n     = '0;
        end else act_idx_n = act_idx + LEN_W'(1);
        DRAIN: if (cnt == CW'(ROWS + COLS - 2)) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else cnt_n = cnt + CW'(1);
        DONE: begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end
        default: begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      endcase
    end
    // Bit 0 mirrors the registered act_en, so it shifts in act_en's next value.
    ps_en_n = (abort && state != IDLE) ? '0 : {ps_en[ROWS-2:0], act_en_n};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      w_load  <= 1'b0;
      w_row   <= '0;
      act_en  <= 1'b0;
      act_idx <= '0;
      ps_en   <= '0;
      cnt     <= '0;
      len_m1  <= '0;
`ifdef SYS_SEQ_WEIGHT_REUSE_EN
      w_valid <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      busy    <= busy_n;
      done    <= done_n;
      w_load  <= w_load_n;
      w_row   <= w_row_n;
      act_en  <= act_en_n;
      act_idx <= act_idx_n;
      ps_en   <= ps_en_n;
      cnt     <= cnt_n;
      len_m1  <= len_m1_n;
`ifdef SYS_SEQ_WEIGHT_REUSE_EN
      w_valid <= w_valid_n;
`endif
    end
  end
endmodule
